// File: rtl/ram_loader_prueba.sv
// ram_loader_prueba: streams a 64x8 read-only image RAM into a 4-PE systolic
// array, one 4-word block at a time. Each word is zero-extended to the PE lane
// width and packed onto data_out. A load_next/tpu_ready handshake with the
// array gates progress from one block to the next.
module ram_loader_prueba #(
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int PE_DATA_WIDTH  = 16,
    parameter int DEPTH          = 4,
    parameter int LATENCY        = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             tpu_ready,
    output logic [PE_DATA_WIDTH*DEPTH-1:0]   data_out,
    output logic                             data_valid,
    output logic                             done,
    output logic                             load_next
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_TPU = 3'd2,
        FINISH   = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int RAM_DEPTH   = 2 ** RAM_ADDR_WIDTH;
    localparam int LOAD_CYCLES = DEPTH + LATENCY;
    localparam int CYC_W       = $clog2(LOAD_CYCLES + 1);
    localparam int WC_W        = $clog2(DEPTH + 1);
    localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // base_addr carries one extra bit so stepping past the last block never wraps
    localparam int BASE_W      = RAM_ADDR_WIDTH + 1;

    localparam logic [CYC_W-1:0]  ISSUE_END     = CYC_W'(DEPTH - 1);
    localparam logic [CYC_W-1:0]  FIRST_CAPTURE = CYC_W'(LATENCY);
    localparam logic [CYC_W-1:0]  LOAD_END      = CYC_W'(LOAD_CYCLES - 1);
    localparam logic [BASE_W-1:0] LAST_BASE     = BASE_W'(RAM_DEPTH - DEPTH);

    state_t                       current_state;
    logic [BASE_W-1:0]            base_addr;
    logic [RAM_ADDR_WIDTH-1:0]    ram_address;
    logic [WC_W-1:0]              word_counter;
    logic [PE_DATA_WIDTH-1:0]     data_buffer [DEPTH];

    logic [CYC_W-1:0]             loadCycle_q;
    logic [RAM_DATA_WIDTH-1:0]    readPipe_q [LATENCY];
    logic [RAM_DATA_WIDTH-1:0]    mem [RAM_DEPTH];

    logic [PE_DATA_WIDTH-1:0]       capturedWord_d;
    logic [IDX_W-1:0]               captureIdx_d;
    logic [PE_DATA_WIDTH*DEPTH-1:0] blockOut_d;

    // Image RAM contents: every 4-word group reads 09, 02, 03, 04
    for (genvar a = 0; a < RAM_DEPTH; a++) begin : g_rom
        assign mem[a] = ((a % 4) == 0) ? RAM_DATA_WIDTH'(9) : RAM_DATA_WIDTH'((a % 4) + 1);
    end

    assign capturedWord_d = PE_DATA_WIDTH'(readPipe_q[LATENCY-1]);
    assign captureIdx_d   = IDX_W'(loadCycle_q - FIRST_CAPTURE);

    // Packed block as it will look once the word arriving now lands in the last lane
    always_comb begin
        blockOut_d = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            blockOut_d[k*PE_DATA_WIDTH +: PE_DATA_WIDTH] = data_buffer[k];
        end
        blockOut_d[(DEPTH-1)*PE_DATA_WIDTH +: PE_DATA_WIDTH] = capturedWord_d;
    end

    // RAM read pipeline: the word at ram_address emerges LATENCY cycles later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                readPipe_q[i] <= '0;
            end
        end else begin
            readPipe_q[0] <= mem[ram_address];
            for (int i = 1; i < LATENCY; i++) begin
                readPipe_q[i] <= readPipe_q[i-1];
            end
        end
    end

    // Block-fetch FSM: issue addresses, capture returning words, handshake with the array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_state <= IDLE;
            base_addr     <= '0;
            ram_address   <= '0;
            word_counter  <= '0;
            loadCycle_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_buffer[k] <= '0;
            end
            data_out      <= '0;
            data_valid    <= 1'b0;
            done          <= 1'b0;
            load_next     <= 1'b0;
        end else begin
            case (current_state)
                IDLE, DONE: begin
                    if (start) begin
                        current_state <= LOAD;
                        base_addr     <= '0;
                        ram_address   <= '0;
                        word_counter  <= '0;
                        loadCycle_q   <= '0;
                        done          <= 1'b0;
                    end
                end

                LOAD: begin
                    if (loadCycle_q < ISSUE_END) begin
                        ram_address <= ram_address + RAM_ADDR_WIDTH'(1);
                    end
                    if (loadCycle_q >= FIRST_CAPTURE) begin
                        data_buffer[captureIdx_d] <= capturedWord_d;
                        word_counter              <= word_counter + WC_W'(1);
                    end
                    if (loadCycle_q == LOAD_END) begin
                        current_state <= WAIT_TPU;
                        data_out      <= blockOut_d;
                        data_valid    <= 1'b1;
                        load_next     <= 1'b1;
                        loadCycle_q   <= '0;
                    end else begin
                        loadCycle_q <= loadCycle_q + CYC_W'(1);
                    end
                end

                WAIT_TPU: begin
                    if (tpu_ready) begin
                        data_valid <= 1'b0;
                        load_next  <= 1'b0;
                        base_addr  <= base_addr + BASE_W'(DEPTH);
                        if (base_addr == LAST_BASE) begin
                            current_state <= FINISH;
                        end else begin
                            current_state <= LOAD;
                            ram_address   <= RAM_ADDR_WIDTH'(base_addr + BASE_W'(DEPTH));
                            word_counter  <= '0;
                            loadCycle_q   <= '0;
                        end
                    end
                end

                FINISH: begin
                    current_state <= DONE;
                    done          <= 1'b1;
                end

                default: begin
                    current_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader_prueba.sv
// tb_ram_loader_prueba: directed bench for the RAM block loader. An array model
// accepts each block about 5 cycles after it is offered; expected values are the
// hand-computed block contents, load latency and base addresses.
module tb_ram_loader_prueba;

    localparam logic [63:0] BLOCK = 64'h0004_0003_0002_0009;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        tpuReady;
    logic [63:0] dataOut;
    logic        dataValid;
    logic        done;
    logic        loadNext;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc;

    ram_loader_prueba dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tpu_ready  (tpuReady),
        .data_out   (dataOut),
        .data_valid (dataValid),
        .done       (done),
        .load_next  (loadNext)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseReady();
        tpuReady = 1'b1;
        @(negedge clk);
        tpuReady = 1'b0;
    endtask

    // Counts cycles until data_valid is seen, giving up after 40
    task automatic waitValid(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (dataValid) break;
        end
        if (!dataValid) checkOutput("validTimeout", dataValid, 1);
    endtask

    // Array model: accepts blocks first..last-1, optionally holding tpu_ready during the next LOAD
    task automatic applyStimulus(input int first, input int last, input bit readyInLoad);
        int lat;
        int expLat;
        expLat = 7;
        for (int b = first; b < last; b++) begin
            waitValid(lat);
            checkOutput($sformatf("latency%0d", b), lat, expLat);
            expLat = 7;
            checkOutput($sformatf("blockData%0d", b), dataOut, BLOCK);
            checkOutput($sformatf("baseAddr%0d", b), dut.base_addr, 4 * b);
            checkOutput("loadNextHigh", loadNext, 1);
            repeat (5) @(negedge clk);
            checkOutput("heldData", dataOut, BLOCK);
            checkOutput("heldValid", dataValid, 1);
            pulseReady();
            checkOutput("validDrop", dataValid, 0);
            checkOutput("loadNextDrop", loadNext, 0);
            if (b == 15) checkOutput("finishState", dut.current_state, 3);
            else         checkOutput("reloadState", dut.current_state, 1);
            if (readyInLoad && b == first) begin
                tpuReady = 1'b1;
                repeat (3) @(negedge clk);
                checkOutput("ignoreReadyState", dut.current_state, 1);
                checkOutput("ignoreReadyBase", dut.base_addr, 4 * (b + 1));
                tpuReady = 1'b0;
                expLat = 4;
            end
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tpuReady = 1'b0;
        #40;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstDataOut", dataOut, 0);
        checkOutput("rstValid", dataValid, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstLoadNext", loadNext, 0);
        checkOutput("rstState", dut.current_state, 0);
        checkOutput("rstBuffer0", dut.data_buffer[0], 0);

        // First block offered, array never answers
        pulseStart();
        waitValid(cyc);
        checkOutput("firstLatency", cyc, 7);
        checkOutput("firstData", dataOut, BLOCK);
        checkOutput("firstLoadNext", loadNext, 1);
        repeat (10) @(negedge clk);
        checkOutput("stallData", dataOut, BLOCK);
        checkOutput("stallValid", dataValid, 1);
        checkOutput("stallState", dut.current_state, 2);

        // Reset while waiting on the array
        reset = 1'b1;
        #1;
        checkOutput("rstWaitValid", dataValid, 0);
        checkOutput("rstWaitData", dataOut, 0);
        @(negedge clk);
        reset = 1'b0;

        // Five blocks with tpu_ready held during a LOAD, then reset mid-LOAD of block 5
        pulseStart();
        applyStimulus(0, 5, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midRstState", dut.current_state, 0);
        checkOutput("midRstData", dataOut, 0);
        checkOutput("midRstValid", dataValid, 0);
        checkOutput("midRstBase", dut.base_addr, 0);
        checkOutput("midRstBuffer1", dut.data_buffer[1], 0);
        checkOutput("midRstCounter", dut.word_counter, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full run of 16 blocks from address 0
        pulseStart();
        applyStimulus(0, 16, 1'b0);
        @(negedge clk);
        checkOutput("doneHigh", done, 1);
        checkOutput("doneState", dut.current_state, 4);
        checkOutput("buffer0", dut.data_buffer[0], 16'h0009);
        checkOutput("buffer1", dut.data_buffer[1], 16'h0002);
        checkOutput("buffer2", dut.data_buffer[2], 16'h0003);
        checkOutput("buffer3", dut.data_buffer[3], 16'h0004);
        repeat (3) @(negedge clk);
        checkOutput("doneHeld", done, 1);

        // Restart from DONE
        pulseStart();
        checkOutput("restartDone", done, 0);
        checkOutput("restartState", dut.current_state, 1);
        applyStimulus(0, 16, 1'b0);
        @(negedge clk);
        checkOutput("doneAgain", done, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ram_loader_prueba.md
Name: ram_loader_prueba

Overview:
- Block-fetch engine that streams an internal 64x8 initialized RAM into a 4-PE systolic array, one 4-word block at a time.
- Each 8-bit word is zero-extended to PE width and packed onto a wide output bus.
- A handshake with the array (load_next / tpu_ready) gates progress between blocks.
- Sits between image memory and the brightness-filter PE row.

Parameters:
- RAM_ADDR_WIDTH, 6, RAM address width; RAM depth = 2**RAM_ADDR_WIDTH = 64 words.
- RAM_DATA_WIDTH, 8, RAM word width.
- PE_DATA_WIDTH, 16, per-PE lane width; words are zero-extended to this width.
- DEPTH, 4, words per block (PE count).
- LATENCY, 3, RAM read latency in cycles (address to data).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a full load from address 0 when in IDLE or DONE.
- tpu_ready  in  1  array accepted the current block; sampled only in WAIT_TPU.
- data_out  out  PE_DATA_WIDTH*DEPTH (64)  packed block; PE0 = [15:0], PE1 = [31:16], PE2 = [47:32], PE3 = [63:48].
- data_valid  out  1  high while a complete block is presented (WAIT_TPU).
- done  out  1  high after the last block is accepted.
- load_next  out  1  request to the array to consume data_out; high in WAIT_TPU.

Behaviour:
- RAM contents (initialized, read-only):
  - mem[a] = 8'h09 when a mod 4 = 0; otherwise mem[a] = (a mod 4) + 1.
  - Every block therefore reads 09, 02, 03, 04.
- Internal registers (hierarchically visible to verification): data_buffer[0..3] (PE_DATA_WIDTH each), word_counter, base_addr, ram_address, current_state.
- States: IDLE, LOAD, WAIT_TPU, FINISH, DONE.
- Reset (asynchronous):
  - state = IDLE.
  - base_addr, ram_address, word_counter = 0.
  - data_buffer all 0; data_out = 0.
  - data_valid, done, load_next = 0.
  - Reset mid-operation aborts immediately; no partial output is retained.
- IDLE: start → LOAD, with base_addr = 0 and word_counter = 0.
- LOAD:
  - Issue ram_address = base_addr + k for k = 0..3 on four consecutive cycles.
  - Read data returns LATENCY cycles after each address.
  - Returned word k is written to data_buffer[k] = {8'h00, word}; word_counter increments per captured word.
  - When the 4th word is captured: go to WAIT_TPU and drive data_out from data_buffer.
  - LOAD lasts DEPTH + LATENCY = 7 cycles.
- WAIT_TPU:
  - data_valid = 1 and load_next = 1; data_out is held stable.
  - On tpu_ready = 1 at a clock edge: deassert data_valid and load_next; base_addr += 4.
  - If the accepted block was the last (base_addr was 60): go to FINISH. Otherwise go to LOAD with word_counter = 0.
  - tpu_ready outside WAIT_TPU is ignored.
  - Waits indefinitely; there is no timeout.
- FINISH: one cycle, then DONE.
- DONE:
  - done = 1, held until reset or start.
  - start in DONE clears done and restarts at address 0, entering LOAD.
- start outside IDLE and DONE is ignored.
- Block count: 2**RAM_ADDR_WIDTH / DEPTH = 16. base_addr never wraps within a run.

Test Plan:
- Reset held 40 ns, then released → all outputs 0, state IDLE, data_out = 0.
- start pulse, tpu_ready never asserted → after 7 cycles: data_valid = 1, load_next = 1, data_out = 64'h0004_0003_0002_0009; stays in WAIT_TPU with output stable.
- Array model pulses tpu_ready one cycle, about 5 cycles after load_next → 16 data_valid rising edges, each with data_out = 0004_0003_0002_0009; base_addr steps 0, 4, ..., 60; then FINISH → done = 1; data_buffer = 0009, 0002, 0003, 0004.
- tpu_ready asserted while in LOAD → ignored; block count and addresses unchanged.
- Reset asserted mid-LOAD (e.g. block 5) → immediate IDLE, outputs 0; a new start reloads from address 0.
- start in DONE → done drops, full 16-block sequence repeats.
